set_cmd_sched: RTL and testbench

Command scheduler that sits directly upstream of the SET region-counting engine. It buffers host requests in a small FIFO. Each request carries centers, radii and mode. The block issues them one at a time over SET's `en`/`busy`/`valid` protocol, captures each `candidate` count and returns it on a valid/ready result port with a sequence tag. This decouples a bursty host from SET's fixed ~80-cycle per-request processing time.

---
 rtl/set_cmd_sched.sv | 155 +++++++++++++++
 tb/tb_set_cmd_sched.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/set_cmd_sched.sv
// Command scheduler in front of the SET region-counting engine: queues host commands,
// issues them one at a time and returns tagged results. Optional watchdog: SET_TIMEOUT_EN.
module set_cmd_sched #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [23:0]                cmd_central,
    input  logic [11:0]                cmd_radius,
    input  logic [1:0]                 cmd_mode,
    output logic                       set_en,
    output logic [23:0]                set_central,
    output logic [11:0]                set_radius,
    output logic [1:0]                 set_mode,
    input  logic                       set_busy,
    input  logic                       set_valid,
    input  logic [7:0]                 set_candidate,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [7:0]                 res_count,
    output logic [1:0]                 res_mode,
    output logic [3:0]                 res_tag,
    output logic                       res_err,
    output logic [$clog2(DEPTH):0]     fifo_level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] DepthW = (AW + 1)'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("set_cmd_sched: DEPTH must be a power of two >= 2");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("set_cmd_sched: TIMEOUT must be in 1..255");
    end

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    logic [37:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   level_q;
    state_e        state_q;
    logic          set_en_q;
    logic [3:0]    tag_q, issue_tag_q;
    logic          push, pop;
    logic [37:0]   head;

    assign cmd_ready  = level_q < DepthW;
    assign push       = cmd_valid && cmd_ready;
    assign pop        = state_q == StIssue;
    assign head       = mem_q[rd_ptr_q];
    assign fifo_level = level_q;
    // Gate with rst so a reset landing on an ISSUE cycle never leaks a start pulse.
    assign set_en     = set_en_q && !rst;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_central, cmd_radius, cmd_mode};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop) begin
                level_q <= level_q + 1'b1;
            end else if (pop && !push) begin
                level_q <= level_q - 1'b1;
            end
        end
    end

`ifdef SET_TIMEOUT_EN
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);
    logic [7:0] wd_q;
`else
    assign res_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            set_en_q    <= 1'b0;
            set_central <= '0;
            set_radius  <= '0;
            set_mode    <= '0;
            res_valid   <= 1'b0;
            res_count   <= '0;
            res_mode    <= '0;
            res_tag     <= '0;
            tag_q       <= '0;
            issue_tag_q <= '0;
`ifdef SET_TIMEOUT_EN
            wd_q        <= '0;
            res_err     <= 1'b0;
`endif
        end else begin
            set_en_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (level_q != '0 && !set_busy) begin
                        state_q                              <= StIssue;
                        set_en_q                             <= 1'b1;
                        {set_central, set_radius, set_mode}  <= head;
                    end
                end
                StIssue: begin
                    issue_tag_q <= tag_q;
                    tag_q       <= tag_q + 1'b1;
                    state_q     <= StWait;
`ifdef SET_TIMEOUT_EN
                    wd_q        <= '0;
`endif
                end
                StWait: begin
                    if (set_valid) begin
                        res_valid <= 1'b1;
                        res_count <= set_candidate;
                        res_mode  <= set_mode;
                        res_tag   <= issue_tag_q;
                        state_q   <= StDone;
`ifdef SET_TIMEOUT_EN
                        res_err   <= 1'b0;
                    end else if (wd_q == TimeoutLast) begin
                        res_valid <= 1'b1;
                        res_count <= '0;
                        res_mode  <= set_mode;
                        res_tag   <= issue_tag_q;
                        res_err   <= 1'b1;
                        state_q   <= StDone;
                    end else begin
                        wd_q <= wd_q + 1'b1;
`endif
                    end
                end
                StDone: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_set_cmd_sched.sv
// Directed self-checking bench for set_cmd_sched with a behavioural SET stub.
// Define SET_TIMEOUT_EN to exercise the watchdog path (TIMEOUT=20).
module tb_set_cmd_sched;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [23:0] cmd_central = '0;
    logic [11:0] cmd_radius = '0;
    logic [1:0]  cmd_mode = '0;
    logic        set_en;
    logic [23:0] set_central;
    logic [11:0] set_radius;
    logic [1:0]  set_mode;
    logic        set_busy;
    logic        set_valid;
    logic [7:0]  set_candidate;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [7:0]  res_count;
    logic [1:0]  res_mode;
    logic [3:0]  res_tag;
    logic        res_err;
    logic [2:0]  fifo_level;

    int tests = 0;
    int fails = 0;

    // SET stub
    logic       stub_busy, stub_valid;
    logic [7:0] stub_cand_q;
    int         stub_cnt;
    int         stub_lat = 5;
    logic [7:0] stub_cand = '0;
    bit         stub_hang = 1'b0;
    bit         force_busy = 1'b0;
    int         en_count = 0;
    int         rst_en_seen = 0;

    assign set_busy      = stub_busy | force_busy;
    assign set_valid     = stub_valid;
    assign set_candidate = stub_cand_q;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) begin
            stub_busy   <= 1'b0;
            stub_valid  <= 1'b0;
            stub_cnt    <= 0;
            stub_cand_q <= '0;
        end else if (set_en) begin
            stub_valid  <= 1'b0;
            stub_busy   <= 1'b1;
            stub_cnt    <= stub_lat;
            stub_cand_q <= stub_cand;
        end else if (stub_busy && !stub_hang) begin
            if (stub_cnt <= 1) begin
                stub_busy  <= 1'b0;
                stub_valid <= 1'b1;
            end else begin
                stub_cnt <= stub_cnt - 1;
            end
        end
    end

    always @(posedge clk) begin
        if (set_en) en_count <= en_count + 1;
        if (rst && set_en) rst_en_seen <= rst_en_seen + 1;
    end

    set_cmd_sched #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_central   (cmd_central),
        .cmd_radius    (cmd_radius),
        .cmd_mode      (cmd_mode),
        .set_en        (set_en),
        .set_central   (set_central),
        .set_radius    (set_radius),
        .set_mode      (set_mode),
        .set_busy      (set_busy),
        .set_valid     (set_valid),
        .set_candidate (set_candidate),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_count     (res_count),
        .res_mode      (res_mode),
        .res_tag       (res_tag),
        .res_err       (res_err),
        .fifo_level    (fifo_level)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        res_ready  = 1'b0;
        force_busy = 1'b0;
        stub_hang  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic push(input logic [1:0] m, input logic [23:0] c, input logic [11:0] r);
        cmd_valid   = 1'b1;
        cmd_mode    = m;
        cmd_central = c;
        cmd_radius  = r;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_res(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (res_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (cmd_ready !== 1'b1) begin
            fails++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready);
        end
        tests++;
        if ({set_en, res_valid, res_err} !== 3'b000) begin
            fails++; $display("FAIL reset_flags: got %b want 000", {set_en, res_valid, res_err});
        end
        tests++;
        if ({set_central, set_radius, set_mode} !== 38'h0) begin
            fails++; $display("FAIL reset_set_fields: got %h want 0", {set_central, set_radius, set_mode});
        end
        tests++;
        if ({res_count, res_mode, res_tag} !== 14'h0) begin
            fails++; $display("FAIL reset_res_fields: got %h want 0", {res_count, res_mode, res_tag});
        end
        tests++;
        if (fifo_level !== 3'd0) begin
            fails++; $display("FAIL reset_fifo_level: got %0d want 0", fifo_level);
        end
    endtask

    task automatic test_single();
        int e0;
        bit ok;
        do_reset();
        stub_lat  = 72;
        stub_cand = 8'd29;
        e0 = en_count;
        push(2'd0, 24'h440000, 12'h300);
        tests++;
        if (fifo_level !== 3'd1 || set_en !== 1'b0) begin
            fails++; $display("FAIL single_after_push: level %0d en %b want 1 0", fifo_level, set_en);
        end
        tick();
        tests++;
        if (set_en !== 1'b1) begin
            fails++; $display("FAIL single_en_latency: got %b want 1", set_en);
        end
        tests++;
        if ({set_central, set_radius, set_mode} !== {24'h440000, 12'h300, 2'd0}) begin
            fails++; $display("FAIL single_set_fields: got %h want %h",
                              {set_central, set_radius, set_mode}, {24'h440000, 12'h300, 2'd0});
        end
        wait_res(200, ok);
        tests++;
        if (!ok) begin
            fails++; $display("FAIL single_wait: res_valid got 0 want 1 within 200 cycles");
        end
        tests++;
        if (res_count !== 8'd29 || res_mode !== 2'd0 || res_tag !== 4'd0 || res_err !== 1'b0) begin
            fails++; $display("FAIL single_result: count %0d mode %0d tag %0d err %b want 29 0 0 0",
                              res_count, res_mode, res_tag, res_err);
        end
        tests++;
        if (en_count - e0 !== 1) begin
            fails++; $display("FAIL single_en_pulses: got %0d want 1", en_count - e0);
        end
        handshake();
        tests++;
        if (res_valid !== 1'b0) begin
            fails++; $display("FAIL single_handshake: res_valid got %b want 0", res_valid);
        end
    endtask

    task automatic test_fill();
        int e0;
        bit ok;
        bit extra;
        do_reset();
        force_busy = 1'b1;
        stub_lat   = 5;
        stub_cand  = 8'h5a;
        e0 = en_count;
        cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cmd_mode    = 2'(i);
            cmd_central = 24'(i + 1);
            cmd_radius  = 12'(i);
            tick();
        end
        tests++;
        if (fifo_level !== 3'd4 || cmd_ready !== 1'b0) begin
            fails++; $display("FAIL fill_full: level %0d ready %b want 4 0", fifo_level, cmd_ready);
        end
        cmd_mode = 2'd0;
        tick();
        cmd_valid = 1'b0;
        tests++;
        if (fifo_level !== 3'd4 || en_count !== e0) begin
            fails++; $display("FAIL fill_fifth_rejected: level %0d en %0d want 4 0",
                              fifo_level, en_count - e0);
        end
        force_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_res(100, ok);
            tests++;
            if (!ok || res_tag !== 4'(i) || res_mode !== 2'(i) || res_count !== 8'h5a) begin
                fails++; $display("FAIL fill_result%0d: valid %b tag %0d mode %0d count %h want 1 %0d %0d 5a",
                                  i, res_valid, res_tag, res_mode, res_count, i, i);
            end
            handshake();
        end
        extra = 1'b0;
        repeat (30) begin
            tick();
            if (res_valid !== 1'b0) extra = 1'b1;
        end
        tests++;
        if (extra || en_count - e0 !== 4 || fifo_level !== 3'd0) begin
            fails++; $display("FAIL fill_drained: extra %b en %0d level %0d want 0 4 0",
                              extra, en_count - e0, fifo_level);
        end
    endtask

    task automatic test_backpressure();
        int e0;
        int bad;
        bit ok;
        do_reset();
        stub_lat  = 10;
        stub_cand = 8'd77;
        push(2'd2, 24'h123456, 12'habc);
        push(2'd1, 24'h654321, 12'h111);
        wait_res(100, ok);
        tests++;
        if (!ok) begin
            fails++; $display("FAIL bp_wait: res_valid got 0 want 1 within 100 cycles");
        end
        e0  = en_count;
        bad = 0;
        repeat (100) begin
            tick();
            if (res_valid !== 1'b1 || res_count !== 8'd77 || res_mode !== 2'd2 ||
                res_tag !== 4'd0 || set_en !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0 || en_count != e0) begin
            fails++; $display("FAIL bp_hold: unstable cycles %0d extra en %0d want 0 0", bad, en_count - e0);
        end
        handshake();
        tests++;
        if (set_en !== 1'b0 || res_valid !== 1'b0) begin
            fails++; $display("FAIL bp_release_edge: en %b valid %b want 0 0", set_en, res_valid);
        end
        tick();
        tests++;
        if (set_en !== 1'b1 || set_mode !== 2'd1) begin
            fails++; $display("FAIL bp_next_issue: en %b mode %0d want 1 1", set_en, set_mode);
        end
        wait_res(100, ok);
        tests++;
        if (!ok || res_tag !== 4'd1 || res_mode !== 2'd1) begin
            fails++; $display("FAIL bp_second: valid %b tag %0d mode %0d want 1 1 1", res_valid, res_tag, res_mode);
        end
        handshake();
    endtask

    task automatic test_tag_wrap();
        bit ok;
        do_reset();
        stub_lat = 3;
        for (int i = 0; i < 17; i++) begin
            stub_cand = 8'(i + 100);
            push(2'(i), 24'(i), 12'(i));
            wait_res(50, ok);
            tests++;
            if (!ok || res_tag !== 4'(i) || res_count !== 8'(i + 100) || res_mode !== 2'(i)) begin
                fails++; $display("FAIL tag_wrap%0d: valid %b tag %0d count %0d mode %0d want 1 %0d %0d %0d",
                                  i, res_valid, res_tag, res_count, res_mode, i % 16, i + 100, i % 4);
            end
            handshake();
        end
    endtask

    task automatic test_reset_mid();
        int e1;
        bit seen;
        do_reset();
        stub_lat = 50;
        push(2'd1, 24'h111111, 12'h111);
        push(2'd2, 24'h222222, 12'h222);
        push(2'd3, 24'h333333, 12'h333);
        tick();
        tick();
        tests++;
        if (fifo_level !== 3'd2 || set_busy !== 1'b1) begin
            fails++; $display("FAIL rstmid_setup: level %0d busy %b want 2 1", fifo_level, set_busy);
        end
        rst = 1'b1;
        tick();
        tests++;
        if (cmd_ready !== 1'b1 || set_en !== 1'b0 || res_valid !== 1'b0 || res_err !== 1'b0 ||
            fifo_level !== 3'd0) begin
            fails++; $display("FAIL rstmid_ctrl: ready %b en %b valid %b err %b level %0d want 1 0 0 0 0",
                              cmd_ready, set_en, res_valid, res_err, fifo_level);
        end
        tests++;
        if ({set_central, set_radius, set_mode, res_count, res_mode, res_tag} !== 52'h0) begin
            fails++; $display("FAIL rstmid_fields: got %h want 0",
                              {set_central, set_radius, set_mode, res_count, res_mode, res_tag});
        end
        rst = 1'b0;
        e1 = en_count;
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (res_valid !== 1'b0) seen = 1'b1;
        end
        tests++;
        if (en_count != e1 || seen) begin
            fails++; $display("FAIL rstmid_quiet: en %0d valid_seen %b want 0 0", en_count - e1, seen);
        end
        tests++;
        if (rst_en_seen != 0) begin
            fails++; $display("FAIL rst_en_overlap: got %0d want 0", rst_en_seen);
        end
    endtask

    task automatic test_timeout();
        bit seen;
        do_reset();
        stub_hang = 1'b1;
        stub_lat  = 5;
        seen      = 1'b0;
        push(2'd3, 24'habcdef, 12'h321);
`ifdef SET_TIMEOUT_EN
        repeat (21) tick();
        tests++;
        if (res_valid !== 1'b0) begin
            fails++; $display("FAIL timeout_early: res_valid got %b want 0", res_valid);
        end
        tick();
        tests++;
        if (res_valid !== 1'b1 || res_err !== 1'b1 || res_count !== 8'd0 ||
            res_mode !== 2'd3 || res_tag !== 4'd0) begin
            fails++; $display("FAIL timeout_fire: valid %b err %b count %0d mode %0d tag %0d want 1 1 0 3 0",
                              res_valid, res_err, res_count, res_mode, res_tag);
        end
        handshake();
        tests++;
        if (res_valid !== 1'b0) begin
            fails++; $display("FAIL timeout_handshake: res_valid got %b want 0", res_valid);
        end
`else
        repeat (300) begin
            tick();
            if (res_valid !== 1'b0) seen = 1'b1;
        end
        tests++;
        if (seen || res_err !== 1'b0) begin
            fails++; $display("FAIL no_timeout: valid_seen %b err %b want 0 0", seen, res_err);
        end
`endif
        do_reset();
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_backpressure();
        test_tag_wrap();
        test_reset_mid();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, %0d tests run", tests);
        $fatal(1);
    end

endmodule
